sram_like_arbiter: RTL

//  Shares one SRAM-like memory port between the fetch requester (inst_*) and the
//  MEM-stage load/store requester (data_*). One transaction in flight at a time.

---
 rtl/sram_like_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// Arbiter that shares one SRAM-like port between the fetch (inst_*) and the MEM (data_*) requesters.
// The optional fetch-starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module sram_like_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W/8-1:0] inst_wstrb,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;   // 1 = data requester owns the port
    logic   force_inst;
    logic   in_addr, in_data;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign force_inst = inst_req && (starve_cnt_q == STARVE_LIM);
`else
    assign force_inst = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef ARB_STARVE_GUARD_EN
        starve_cnt_d = starve_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (data_req && !force_inst) begin
                    owner_d = 1'b1;
                    state_d = S_ADDR;
`ifdef ARB_STARVE_GUARD_EN
                    if (inst_req && (starve_cnt_q < STARVE_LIM))
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
`endif
                end else if (inst_req) begin
                    owner_d = 1'b0;
                    state_d = S_ADDR;
`ifdef ARB_STARVE_GUARD_EN
                    starve_cnt_d = '0;
`endif
                end
            end
            // A requester dropping req here is a protocol error; we keep presenting it.
            S_ADDR: if (bus_addr_ok) state_d = S_DATA;
            S_DATA: if (bus_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign in_addr = (state_q == S_ADDR);
    assign in_data = (state_q == S_DATA);

    // Bus fields are zeroed outside the address phase so nothing leaks while idle.
    assign bus_req   = in_addr;
    assign bus_wr    = in_addr & (owner_q ? data_wr : inst_wr);
    assign bus_size  = in_addr ? (owner_q ? data_size  : inst_size)  : '0;
    assign bus_addr  = in_addr ? (owner_q ? data_addr  : inst_addr)  : '0;
    assign bus_wstrb = in_addr ? (owner_q ? data_wstrb : inst_wstrb) : '0;
    assign bus_wdata = in_addr ? (owner_q ? data_wdata : inst_wdata) : '0;

    assign inst_addr_ok = in_addr & ~owner_q & bus_addr_ok;
    assign data_addr_ok = in_addr &  owner_q & bus_addr_ok;
    assign inst_data_ok = in_data & ~owner_q & bus_data_ok;
    assign data_data_ok = in_data &  owner_q & bus_data_ok;

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

endmodule
